// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    // Operation encoding as presented by the main decoder.
    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_t;

    // Sequencer states.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    // Widest operand supported; DIV0_LO is sliced down to the instance width.
    localparam int MAX_WIDTH = 64;

    // LO value returned by a divide by zero.
    localparam logic [MAX_WIDTH-1:0] DIV0_LO = {MAX_WIDTH{1'b1}};

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide. A single
// WIDTH+1-bit adder is shared: it adds the multiplicand, or subtracts the
// divisor from the shifted partial remainder. For divide, acc_out[0] is left
// zero; the quotient bit is the no_borrow flag and is merged by the caller.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   operand,
    input  logic               div_mode,
    output logic [2*WIDTH-1:0] acc_out,
    output logic               no_borrow
);

    logic [WIDTH:0] op_a_s;
    logic [WIDTH:0] op_b_s;
    logic [WIDTH:0] sum_s;

    // Shared add/subtract and the shift that follows it.
    always_comb begin
        op_a_s    = {1'b0, acc_in[2*WIDTH-1:WIDTH]};
        op_b_s    = {1'b0, operand};
        sum_s     = {(WIDTH+1){1'b0}};
        no_borrow = 1'b0;
        acc_out   = acc_in;
        if (div_mode) begin
            // Partial remainder shifted left, pulling in the next dividend bit.
            op_a_s    = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
            op_b_s    = ~{1'b0, operand};
            sum_s     = op_a_s + op_b_s + {{WIDTH{1'b0}}, 1'b1};
            // The remainder invariant (rem < divisor) makes bit WIDTH a true borrow.
            no_borrow = ~sum_s[WIDTH];
            if (no_borrow) begin
                acc_out = {sum_s[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
            end else begin
                acc_out = {acc_in[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            sum_s = op_a_s + op_b_s;
            if (acc_in[0]) begin
                acc_out = {sum_s, acc_in[WIDTH-1:1]};
            end else begin
                acc_out = {1'b0, acc_in[2*WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner and sequencer for MULT/MULTU/DIV/DIVU. Operands are reduced to
// magnitudes on start, iterated WIDTH times, then sign-corrected in FIX.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t               state_r;
    state_t               state_s;
    logic [CW-1:0]        cnt_r;
    op_t                  op_r;
    logic                 sign_a_r;
    logic                 sign_b_r;
    logic [WIDTH-1:0]     opnd_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;
    logic                 busy_r;
    logic                 done_r;

    logic                 open_s;
    logic                 accept_s;
    logic                 sign_a_s;
    logic                 sign_b_s;
    logic [WIDTH-1:0]     mag_a_s;
    logic [WIDTH-1:0]     mag_b_s;
    logic                 div_mode_s;
    logic [2*WIDTH-1:0]   step_acc_s;
    logic                 step_nb_s;
    logic [2*WIDTH-1:0]   acc_next_s;
    logic [WIDTH-1:0]     res_hi_s;
    logic [WIDTH-1:0]     res_lo_s;

    // Only IDLE and DONE accept a new operation or an MTHI/MTLO write.
    assign open_s     = (state_r == S_IDLE) || (state_r == S_DONE);
    assign accept_s   = start && open_s;
    assign div_mode_s = (op_r == OP_DIVU) || (op_r == OP_DIV);

    assign sign_a_s = op[0] && a[WIDTH-1];
    assign sign_b_s = op[0] && b[WIDTH-1];
    assign mag_a_s  = sign_a_s ? -a : a;
    assign mag_b_s  = sign_b_s ? -b : b;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_in    (acc_r),
        .operand   (opnd_r),
        .div_mode  (div_mode_s),
        .acc_out   (step_acc_s),
        .no_borrow (step_nb_s)
    );

    // Merge the quotient bit into the shifted accumulator for divides.
    always_comb begin
        acc_next_s = step_acc_s;
        if (div_mode_s) begin
            acc_next_s = {step_acc_s[2*WIDTH-1:1], step_nb_s};
        end else begin
            acc_next_s = step_acc_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_s = S_CALC;
                else       state_s = S_IDLE;
            end
            S_CALC: begin
                if (cnt_r == LAST_CNT) state_s = S_FIX;
                else                   state_s = S_CALC;
            end
            S_FIX:  state_s = S_DONE;
            S_DONE: begin
                if (start) state_s = S_CALC;
                else       state_s = S_IDLE;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Sign correction of the raw magnitude result; divide by zero returns the
    // all-ones quotient and the original dividend (its magnitude re-signed).
    always_comb begin
        res_hi_s = acc_r[2*WIDTH-1:WIDTH];
        res_lo_s = acc_r[WIDTH-1:0];
        if (!div_mode_s) begin
            if ((op_r == OP_MULT) && (sign_a_r ^ sign_b_r)) begin
                {res_hi_s, res_lo_s} = -acc_r;
            end else begin
                {res_hi_s, res_lo_s} = acc_r;
            end
        end else if (opnd_r == {WIDTH{1'b0}}) begin
            res_lo_s = DIV0_LO[WIDTH-1:0];
            if (sign_a_r) res_hi_s = -acc_r[2*WIDTH-1:WIDTH];
            else          res_hi_s = acc_r[2*WIDTH-1:WIDTH];
        end else begin
            if (sign_a_r ^ sign_b_r) res_lo_s = -acc_r[WIDTH-1:0];
            else                     res_lo_s = acc_r[WIDTH-1:0];
            if (sign_a_r) res_hi_s = -acc_r[2*WIDTH-1:WIDTH];
            else          res_hi_s = acc_r[2*WIDTH-1:WIDTH];
        end
    end

    // State register and iteration counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                cnt_r <= {CW{1'b0}};
            end else if (state_r == S_CALC) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    // Operand capture on start and one accumulator step per CALC cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_r     <= OP_MULTU;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            opnd_r   <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
        end else if (accept_s) begin
            op_r     <= op_t'(op);
            sign_a_r <= sign_a_s;
            sign_b_r <= sign_b_s;
            if (op[1]) begin
                opnd_r <= mag_b_s;
                acc_r  <= {{WIDTH{1'b0}}, mag_a_s};
            end else begin
                opnd_r <= mag_a_s;
                acc_r  <= {{WIDTH{1'b0}}, mag_b_s};
            end
        end else if (state_r == S_CALC) begin
            acc_r <= acc_next_s;
        end
    end

    // HI/LO: result at FIX, MTHI/MTLO only while the unit is not busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
        end else if (state_r == S_FIX) begin
            hi_r <= res_hi_s;
            lo_r <= res_lo_s;
        end else if (open_s) begin
            if (hi_we) hi_r <= wd;
            if (lo_we) lo_r <= wd;
        end
    end

    // Registered status flags decoded from the upcoming state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s == S_CALC) || (state_s == S_FIX);
            done_r <= (state_s == S_DONE);
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed table, random ops against an
// arithmetic reference model, and hand-written reset / back-to-back sequences.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b, wd;
    logic         hi_we, lo_we;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.WIDTH(W), .CW(6)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wd(wd), .busy(busy), .done(done),
        .hi(hi), .lo(lo)
    );

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            2'b00: return ux * uy;
            2'b01: begin q = sx * sy; return 64'(q); end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (o == 2'b10) return {32'(ux % uy), 32'(ux / uy)};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Drive a start (call at a negedge); returns #1 after the start edge.
    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Count negedges until done; busy must stay high until done appears.
    task automatic wait_done(output logic [63:0] res, output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (done === 1'b1) break;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        if (busy !== 1'b0) busy_ok = 1'b0;
        res = {hi, lo};
    endtask

    task automatic run_and_check(input string name, input logic [1:0] o, input logic [31:0] x,
                                 input logic [31:0] y, input logic [63:0] exp);
        logic [63:0] res; int lat; bit bok;
        @(negedge clk);
        launch(o, x, y);
        wait_done(res, lat, bok);
        check({name, ".result"}, res, exp);
        check({name, ".latency"}, 64'(lat), 64'(W + 2));
        check({name, ".busy"}, 64'(bok), 64'd1);
    endtask

    vec_t vecs[8];

    initial begin
        logic [63:0] res;
        logic [31:0] x, y, save_hi;
        logic [1:0]  o;
        int lat;
        bit bok;

        reset_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wd = '0;

        vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4] = '{OP_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
        vecs[5] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[6] = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[7] = '{OP_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};

        // Reset state.
        #12;
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                          {vecs[i].hi, vecs[i].lo});
        end

        // MTLO then MTHI in IDLE.
        @(negedge clk);
        save_hi = hi;
        lo_we = 1'b1; wd = 32'h0000_1234;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo.lo", 64'(lo), 64'h1234);
        check("mtlo.hi", 64'(hi), 64'(save_hi));
        hi_we = 1'b1; wd = 32'hCAFE_0001;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi.hi", 64'(hi), 64'hCAFE_0001);
        check("mthi.lo", 64'(lo), 64'h1234);

        // Randomized ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            x = pick();
            y = pick();
            run_and_check($sformatf("rand%0d op%0d %h %h", i, o, x, y), o, x, y, model(o, x, y));
        end

        // Reset in the middle of a MULT clears everything at once.
        @(negedge clk);
        launch(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007);
        repeat (10) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midreset.busy", 64'(busy), 64'd0);
        check("midreset.done", 64'(done), 64'd0);
        check("midreset.hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Back-to-back: second start lands in the DONE cycle of a DIVU.
        run_and_check("b2b.first", OP_DIVU, 32'd1000, 32'd7, model(2'b10, 32'd1000, 32'd7));
        launch(OP_MULTU, 32'h0001_0000, 32'h0003_0000);
        wait_done(res, lat, bok);
        check("b2b.second.result", res, 64'h0000_0003_0000_0000);
        check("b2b.second.latency", 64'(lat), 64'(W + 2));
        check("b2b.second.busy", 64'(bok), 64'd1);

        // MTLO in the DONE cycle overwrites the fresh result.
        @(negedge clk);
        launch(OP_MULTU, 32'd5, 32'd6);
        wait_done(res, lat, bok);
        check("done_mt.result", res, 64'd30);
        lo_we = 1'b1; wd = 32'h0BAD_F00D;
        @(negedge clk);
        lo_we = 1'b0;
        check("done_mt.lo", 64'(lo), 64'h0BAD_F00D);
        check("done_mt.hi", 64'(hi), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so a stuck DUT cannot hang the run.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer that owns the HI/LO register pair for the single-cycle MIPS core.
- Executes MULT, MULTU, DIV and DIVU over WIDTH iterations, using one shared add/subtract step.
- Raises busy so the core stalls on MFHI/MFLO and on a new mult/div, and accepts MTHI/MTLO writes.
- Sits beside the ALU and is driven by the main decoder.

Parameters:
- WIDTH, 32: operand width and iteration count.
- CW, 6: iteration counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  reset; asynchronous and active-low.
- start  in  1  begin an operation; sampled only in IDLE or DONE.
- op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  in  WIDTH  multiplicand / dividend (rs).
- b  in  WIDTH  multiplier / divisor (rt).
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wd  in  WIDTH  MTHI/MTLO write data.
- busy  out  1  high in CALC and FIX; the core stalls while high.
- done  out  1  one-cycle pulse; hi and lo hold the new result while high.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset_n=0, takes effect immediately, including mid-operation): state=IDLE, hi=lo=0, busy=0, done=0, counter=0. Any partial result is discarded.
- States and transitions:
  - IDLE: start=1 goes to CALC; otherwise stay.
  - CALC: counter runs 0..WIDTH-1, one iteration per cycle; after the last iteration go to FIX.
  - FIX: apply sign correction, write hi/lo, go to DONE.
  - DONE: done=1; go to CALC if start=1, else go to IDLE.
- Latency: with start sampled at edge k, hi/lo update at edge k+WIDTH+1 and done is high in the cycle after that edge. busy is high from edge k until edge k+WIDTH+1.
- On start, the block latches op, the magnitudes of a and b, and the sign flags:
  - Signed ops (op[0]=1): magnitude taken when the MSB is set.
  - Unsigned ops: operands taken raw, sign flags cleared.
- Multiply:
  - Shift-add, LSB-first; the 2*WIDTH-bit product accumulates in {hi_acc, lo_acc}.
  - For MULT, if sign(a) XOR sign(b), FIX applies the 2*WIDTH-bit two's-complement negation.
- Divide:
  - Restoring division: each iteration shifts {rem, quo} left 1, trial-subtracts the divisor from rem, and keeps the result and sets the quotient bit when there is no borrow.
  - DIV sign rules: quotient is negated if the operand signs differ; remainder is negated if the dividend is negative.
  - Result placement: lo = quotient, hi = remainder.
- Divide-by-zero (b=0, any divide op): no trap; the full WIDTH cycles still run; result is lo = all ones, hi = a (original value). The FIX sign logic is bypassed.
- Signed overflow (0x80000000 / 0xFFFFFFFF, DIV): lo=0x80000000, hi=0. This falls out of the magnitude path and needs no special case.
- start while busy: ignored.
- hi_we/lo_we while busy: ignored; the core guarantees none.
- hi_we/lo_we in IDLE or DONE: written on the edge.
  - If start occurs in the same cycle, both take effect; the operation result later overwrites hi/lo at FIX.
  - An MTHI/MTLO in the DONE cycle overwrites the value just produced.
- Writes use wd; hi_we and lo_we are independent.
- hi and lo are registered outputs; they change only at FIX, at an MT write, or at reset.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings: OP_MULTU, OP_MULT, OP_DIVU, OP_DIV;
  - state encodings: S_IDLE, S_CALC, S_FIX, S_DONE (2 bits);
  - constant DIV0_LO = all ones.
- Sub-module muldiv_step: combinational single-iteration datapath.
  - Inputs: accumulator, operand, mode.
  - Outputs: next accumulator and the no-borrow flag.
  - Uses one WIDTH+1-bit adder/subtractor.
- The FSM, counter, sign handling and HI/LO registers stay in muldiv_ctrl.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done exactly 34 cycles after the start edge; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064.
- MTLO wd=0x1234 in IDLE -> lo=0x1234, hi unchanged.
- Reset and back-to-back start:
  - Assert reset_n=0 at iteration 10 of a MULT -> busy=0, hi=lo=0 immediately.
  - After release, start in the DONE cycle of a DIVU -> second op begins with no IDLE cycle; busy stays high until its own FIX edge.
